// File: rtl/prbs_gen_chk.sv
// Fibonacci LFSR PRBS generator plus a self-synchronising checker (hunt/lock/unlock, saturating error count).
// All outputs are registered and there is no backpressure. The checker only acts on cycles with chk_valid_i.
module prbs_gen_chk #(
  parameter int W          = 8,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CW         = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [W-1:0]  seed_i,
  input  logic [W-1:0]  mask_i,
  output logic          gen_out_o,
  output logic [W-1:0]  gen_state_o,
  input  logic          chk_valid_i,
  input  logic          chk_in_i,
  output logic          chk_locked_o,
  output logic          chk_err_o,
  output logic [CW-1:0] err_cnt_o,
  input  logic          err_clr_i
);

  localparam int FW = $clog2(W + 1);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(W);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_CNT - 1);

  typedef enum logic {HUNT, LOCKED} chk_state_e;

  logic [W-1:0]  s_q, s_d, step_s;
  logic          gen_out_q, gen_out_d;
  chk_state_e    state_q, state_d;
  logic [W-1:0]  ref_q, ref_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pred, miss, count_err;

  always_comb begin
    s_d       = s_q;
    gen_out_d = gen_out_q;
    step_s    = {s_q[W-2:0], ^(s_q & mask_i)};
    if (load_i) begin
      s_d = (seed_i == '0) ? '1 : seed_i;
    end else if (en_i) begin
      // A degenerate mask can shift the register to all zeros; reseed instead of sticking.
      s_d       = (step_s == '0) ? '1 : step_s;
      gen_out_d = s_q[W-1];
    end
  end

  assign pred = ^(ref_q & mask_i);
  assign miss = chk_in_i != pred;

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    fill_d    = fill_q;
    good_d    = good_q;
    bad_d     = bad_q;
    err_d     = 1'b0;
    count_err = 1'b0;
    if (chk_valid_i) begin
      case (state_q)
        HUNT: begin
          ref_d = {ref_q[W-2:0], chk_in_i};
          if (fill_q < FILL_FULL) begin
            fill_d = fill_q + 1'b1;
          end else if (miss) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          // Free-run on our own prediction so received errors never corrupt the reference.
          ref_d = {ref_q[W-2:0], pred};
          if (miss) begin
            err_d     = 1'b1;
            count_err = 1'b1;
            if (bad_q == BAD_LAST) begin
              state_d = HUNT;
              fill_d  = '0;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end else begin
            bad_d = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr_i) begin
      cnt_d = {{(CW-1){1'b0}}, count_err};
    end else if (count_err && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_q       <= '1;
      gen_out_q <= 1'b1;
      state_q   <= HUNT;
      ref_q     <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      bad_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s_q       <= s_d;
      gen_out_q <= gen_out_d;
      state_q   <= state_d;
      ref_q     <= ref_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gen_out_o    = gen_out_q;
  assign gen_state_o  = s_q;
  assign chk_locked_o = (state_q == LOCKED);
  assign chk_err_o    = err_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: a bit-history reference model is compared every cycle, and literal
// expectations pin generator sequence, lock timing, error counting, saturation and reset.
`timescale 1ns/1ps
module tb_prbs_gen_chk;
  localparam int W = 8;
  localparam int LOCK_CNT = 16;
  localparam int UNLOCK_CNT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, load, chk_valid, chk_in, err_clr;
  logic [W-1:0] seed, mask;
  logic gen_out, gen_out4, locked, locked4, err, err4;
  logic [W-1:0] state, state4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  prbs_gen_chk #(.W(W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CW(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_i(seed), .mask_i(mask),
    .gen_out_o(gen_out), .gen_state_o(state), .chk_valid_i(chk_valid), .chk_in_i(chk_in),
    .chk_locked_o(locked), .chk_err_o(err), .err_cnt_o(cnt), .err_clr_i(err_clr));

  prbs_gen_chk #(.W(W), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CW(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .load_i(load), .seed_i(seed), .mask_i(mask),
    .gen_out_o(gen_out4), .gen_state_o(state4), .chk_valid_i(chk_valid), .chk_in_i(chk_in),
    .chk_locked_o(locked4), .chk_err_o(err4), .err_cnt_o(cnt4), .err_clr_i(err_clr));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the checker window is a bit history, newest at the back.
  logic [W-1:0] m_s;
  bit m_go, m_locked, m_err, started;
  int m_fill, m_good, m_bad, m_cnt, m_cnt4;
  bit hist[$];

  function automatic bit predict();
    bit p = 1'b0;
    for (int i = 0; i < W; i++)
      if (mask[i]) p ^= hist[hist.size() - 1 - i];
    return p;
  endfunction

  always @(posedge clk) begin
    bit p, counted;
    logic [W-1:0] nxt;
    started = 1'b1;
    if (rst) begin
      m_s = '1; m_go = 1'b1; m_locked = 1'b0; m_err = 1'b0;
      m_fill = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_cnt4 = 0;
      hist.delete();
      for (int i = 0; i < W; i++) hist.push_back(1'b0);
    end else begin
      if (load) begin
        m_s = (seed == '0) ? '1 : seed;
      end else if (en) begin
        m_go = m_s[W-1];
        nxt  = (m_s << 1) | W'($countones(m_s & mask) % 2);
        m_s  = (nxt == '0) ? '1 : nxt;
      end
      counted = 1'b0;
      m_err = 1'b0;
      if (chk_valid) begin
        p = predict();
        if (!m_locked) begin
          hist.push_back(chk_in); void'(hist.pop_front());
          if (m_fill < W) m_fill++;
          else if (chk_in == p) begin
            m_good++;
            if (m_good == LOCK_CNT) begin m_locked = 1'b1; m_good = 0; m_bad = 0; end
          end else m_good = 0;
        end else begin
          hist.push_back(p); void'(hist.pop_front());
          if (chk_in != p) begin
            counted = 1'b1; m_err = 1'b1; m_bad++;
            if (m_bad == UNLOCK_CNT) begin m_locked = 1'b0; m_fill = 0; m_good = 0; m_bad = 0; end
          end else m_bad = 0;
        end
      end
      if (err_clr) begin m_cnt = counted; m_cnt4 = counted; end
      else if (counted) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("gen_out", gen_out, m_go);
      check("gen_state", state, m_s);
      check("chk_locked", locked, m_locked);
      check("chk_err", err, m_err);
      check("err_cnt", cnt, m_cnt);
      check("gen_state_cw4", state4, m_s);
      check("chk_locked_cw4", locked4, m_locked);
      check("err_cnt_cw4", cnt4, m_cnt4);
    end
  end

  int nv, pulses;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic loop_bit(input bit v, input bit flip);
    en = v; chk_valid = v; chk_in = gen_out ^ flip;
    tick();
    if (v) nv++;
    if (err === 1'b1) pulses++;
  endtask

  task automatic run_clean(input int n);
    int got = 0;
    int guard = 0;
    bit v;
    while (got < n && guard < 10 * n + 10) begin
      v = ($urandom_range(0, 3) != 0);
      loop_bit(v, 1'b0);
      if (v) got++;
      guard++;
    end
  endtask

  task automatic lock_run(input string name);
    int guard = 0;
    bit v;
    nv = 0;
    while (nv < W + LOCK_CNT && guard < 300) begin
      v = ($urandom_range(0, 3) != 0);
      loop_bit(v, 1'b0);
      if (v && nv >= W + LOCK_CNT - 1) check(name, locked, nv >= W + LOCK_CNT);
      guard++;
    end
    check({name, "_bits"}, nv, W + LOCK_CNT);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    int guard;
    rst = 1; en = 0; load = 0; seed = '0; mask = 8'hB8;
    chk_valid = 0; chk_in = 0; err_clr = 0;
    nv = 0; pulses = 0;
    tick(); tick();
    check("rst_state", state, 8'hFF);
    check("rst_gen_out", gen_out, 1'b1);
    check("rst_locked", locked, 1'b0);
    check("rst_err_cnt", cnt, 16'h0);

    // Generator sequence and maximal period.
    rst = 0; en = 1;
    seen = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k <= 9) check("gen_bit", gen_out, (k <= 8) ? 1'b1 : 1'b0);
      if (k == 8) check("state_after_8", state, 8'h0B);
      if (k < 255 && state == 8'hFF) seen = 1;
    end
    check("period_255", state, 8'hFF);
    check("no_early_ff", seen, 1'b0);

    // Seed loading.
    en = 0; load = 1; seed = 8'h00; tick();
    check("load_zero_seed", state, 8'hFF);
    seed = 8'h5A; tick();
    check("load_5a", state, 8'h5A);
    en = 1; seed = 8'h3C; tick();
    check("load_beats_en", state, 8'h3C);
    check("load_keeps_out", gen_out, 1'b0);
    load = 0; en = 0;

    // Degenerate mask must never reach the all-zero state.
    mask = 8'h00; en = 1; seen = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (state == 8'h00) seen = 1;
      if (k == 6) check("lockup_reseed", state, 8'hFF);
    end
    check("never_zero", seen, 1'b0);
    en = 0; tick();
    mask = 8'hB8; tick();
    en = 1; tick();
    en = 0;

    // Loopback lock with random gaps, then a long clean run.
    lock_run("lock_time");
    run_clean(1000);
    check("clean_err_cnt", cnt, 16'd0);
    check("clean_locked", locked, 1'b1);

    // Three isolated errors.
    pulses = 0;
    for (int e = 0; e < 3; e++) begin
      run_clean($urandom_range(5, 12));
      loop_bit(1'b1, 1'b1);
    end
    run_clean(5);
    check("iso_pulses", pulses, 3);
    check("iso_err_cnt", cnt, 16'd3);
    check("iso_locked", locked, 1'b1);

    // Four consecutive errors force loss of lock.
    for (int e = 0; e < 4; e++) loop_bit(1'b1, 1'b1);
    check("burst_unlock", locked, 1'b0);
    check("burst_err_cnt", cnt, 16'd7);
    lock_run("relock_time");

    // Saturation of the narrow counter.
    for (int e = 0; e < 20; e++) begin
      loop_bit(1'b1, 1'b1);
      run_clean($urandom_range(3, 6));
    end
    check("sat_err_cnt", cnt, 16'd27);
    check("sat_err_cnt_cw4", cnt4, 4'd15);
    check("sat_locked", locked, 1'b1);

    // Clear coinciding with an error, then clear alone.
    err_clr = 1; loop_bit(1'b1, 1'b1); err_clr = 0;
    check("clr_with_err", cnt, 16'd1);
    check("clr_with_err_cw4", cnt4, 4'd1);
    run_clean(3);
    err_clr = 1; loop_bit(1'b1, 1'b0); err_clr = 0;
    check("clr_alone", cnt, 16'd0);

    // Reset while locked mid-stream.
    loop_bit(1'b1, 1'b1);
    run_clean(3);
    rst = 1; loop_bit(1'b1, 1'b0); rst = 0;
    check("midrst_locked", locked, 1'b0);
    check("midrst_err_cnt", cnt, 16'd0);
    check("midrst_state", state, 8'hFF);
    nv = 0; guard = 0;
    while (locked !== 1'b1 && guard < 200) begin
      loop_bit($urandom_range(0, 3) != 0, 1'b0);
      guard++;
    end
    check("midrst_relock", locked, 1'b1);
    run_clean(20);
    check("midrst_final_cnt", cnt, 16'd0);

    en = 0; chk_valid = 0;
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
